hatch_stage_ctrl: RTL and testbench



---
 rtl/hatch_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_hatch_stage_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hatch_stage_ctrl.sv
// Upstream controller for the egg-hatching dot-matrix display: advances a
// hatch stage index while the incubator temperature stays in range.
module hatch_stage_ctrl #(
    parameter int         TICKS_PER_STAGE = 1000,
    parameter logic [3:0] LAST_STAGE      = 4'd11,
    parameter logic [5:0] TEMP_INIT       = 6'd37,
    parameter logic [5:0] TEMP_LO         = 6'd36,
    parameter logic [5:0] TEMP_HI         = 6'd38,
    parameter logic [5:0] TEMP_MIN        = 6'd30,
    parameter logic [5:0] TEMP_MAX        = 6'd45
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       temp_up,
    input  logic       temp_down,
    output logic [3:0] num,
    output logic       temp,
    output logic       st,
    output logic       done,
    output logic [5:0] temp_val
);

    localparam int CW = (TICKS_PER_STAGE > 1) ? $clog2(TICKS_PER_STAGE) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_STAGE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    num_q, num_d;
    logic [CW-1:0] tick_q, tick_d;
    logic [5:0]    temp_q, temp_d;
    logic          temp_hot;

    assign temp_hot = (temp_q < TEMP_LO) || (temp_q > TEMP_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= 4'd0;
            tick_q  <= '0;
            temp_q  <= TEMP_INIT;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            tick_q  <= tick_d;
            temp_q  <= temp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        tick_d  = tick_q;
        temp_d  = temp_q;

        // Simultaneous up/down cancel; both directions saturate.
        if (temp_up && !temp_down && (temp_q < TEMP_MAX)) begin
            temp_d = temp_q + 6'd1;
        end else if (temp_down && !temp_up && (temp_q > TEMP_MIN)) begin
            temp_d = temp_q - 6'd1;
        end

        if (stop) begin
            state_d = IDLE;
            num_d   = 4'd0;
            tick_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    num_d  = 4'd0;
                    tick_d = '0;
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (temp_hot) begin
                        state_d = HOLD;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        num_d  = num_q + 4'd1;
                        if ((num_q + 4'd1) == LAST_STAGE) begin
                            state_d = DONE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (!temp_hot) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    num_d  = LAST_STAGE;
                    tick_d = '0;
                    // A restart overrides any temperature step in the same cycle.
                    if (start) begin
                        state_d = RUN;
                        num_d   = 4'd0;
                        temp_d  = TEMP_INIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                    num_d   = 4'd0;
                    tick_d  = '0;
                end
            endcase
        end
    end

    assign num      = num_q;
    assign temp     = temp_hot;
    assign st       = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign temp_val = temp_q;

endmodule

// File: tb/tb_hatch_stage_ctrl.sv
// Self-checking bench for hatch_stage_ctrl: directed scenarios plus random
// pulses, compared against a progress-count model of incubation.
module tb_hatch_stage_ctrl;

    localparam int TPS  = 4;
    localparam int LAST = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, tempUp, tempDown;
    logic [3:0] num;
    logic       temp, st, done;
    logic [5:0] tempVal;

    int checks = 0;
    int errors = 0;

    // Model: total elapsed counting cycles since (re)start, plus flags.
    int mProg;
    int mTemp;
    bit mActive;
    bit mHeld;
    bit mDone;

    hatch_stage_ctrl #(
        .TICKS_PER_STAGE(TPS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .temp_up  (tempUp),
        .temp_down(tempDown),
        .num      (num),
        .temp     (temp),
        .st       (st),
        .done     (done),
        .temp_val (tempVal)
    );

    always #5 clk = ~clk;

    function automatic bit modelHot();
        return (mTemp < 36) || (mTemp > 38);
    endfunction

    task automatic modelReset();
        mProg   = 0;
        mTemp   = 37;
        mActive = 1'b0;
        mHeld   = 1'b0;
        mDone   = 1'b0;
    endtask

    // Advances the model by one clock edge using the pre-edge temperature.
    task automatic modelEdge(input bit s, input bit p, input bit u, input bit d);
        bit hot;
        hot = modelHot();
        if (u && !d && mTemp < 45) mTemp = mTemp + 1;
        else if (d && !u && mTemp > 30) mTemp = mTemp - 1;
        if (p) begin
            mActive = 1'b0;
            mProg   = 0;
            mHeld   = 1'b0;
            mDone   = 1'b0;
        end else if (!mActive) begin
            if (s) begin
                mActive = 1'b1;
                mProg   = 0;
                mHeld   = 1'b0;
            end
        end else if (mDone) begin
            if (s) begin
                mDone = 1'b0;
                mProg = 0;
                mTemp = 37;
                mHeld = 1'b0;
            end
        end else if (hot) begin
            mHeld = 1'b1;
        end else if (mHeld) begin
            mHeld = 1'b0;
        end else begin
            mProg = mProg + 1;
            if (mProg == LAST * TPS) mDone = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] eNum;
        logic [5:0] eTemp;
        eNum  = 4'(mProg / TPS);
        eTemp = 6'(mTemp);
        checks++;
        assert (num === eNum) else begin
            errors++;
            $error("[TB] FAIL %s num: observed %0d expected %0d", tag, num, eNum);
        end
        checks++;
        assert (tempVal === eTemp) else begin
            errors++;
            $error("[TB] FAIL %s temp_val: observed %0d expected %0d", tag, tempVal, eTemp);
        end
        checks++;
        assert (temp === modelHot()) else begin
            errors++;
            $error("[TB] FAIL %s temp: observed %b expected %b", tag, temp, modelHot());
        end
        checks++;
        assert (st === mActive) else begin
            errors++;
            $error("[TB] FAIL %s st: observed %b expected %b", tag, st, mActive);
        end
        checks++;
        assert (done === mDone) else begin
            errors++;
            $error("[TB] FAIL %s done: observed %b expected %b", tag, done, mDone);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit p, input bit u, input bit d,
                                 input string tag);
        start    = s;
        stop     = p;
        tempUp   = u;
        tempDown = d;
        @(posedge clk);
        modelEdge(s, p, u, d);
        #1;
        start    = 1'b0;
        stop     = 1'b0;
        tempUp   = 1'b0;
        tempDown = 1'b0;
        checkOutput(tag);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        tempUp   = 1'b0;
        tempDown = 1'b0;
        modelReset();
        #12;
        checkOutput("reset");
        rst = 1'b0;

        // Full incubation run to DONE, then linger there.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "start");
        idleCycles(LAST * TPS, "run");
        idleCycles(6, "doneHold");

        // Restart from DONE, then overheat at stage 3 and recover.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "restart");
        idleCycles(3 * TPS, "run2");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "up1");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "up2");
        idleCycles(20, "hold");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "down1");
        idleCycles(10, "resume");

        // Temperature saturation while idle.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "stop");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "satLow");
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "satHigh");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "upDown");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "backTo37");

        // start+stop together at stage 5: stop wins.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "start3");
        idleCycles(5 * TPS, "run3");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "startStop");
        idleCycles(3, "idle");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "start4");
        idleCycles(7 * TPS, "run4");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "upTo40");

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncReset");
        #1 rst = 1'b0;

        // Random pulses.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
